// File: rtl/arb_types.sv
// Shared types and default constants for the N-channel memory arbiter.
package arb_types;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int DEF_NUM_CH = 2;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_LINE_W = 256;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arb_picker.sv
// Combinational winner search: first set request found scanning start_i, start_i+1, ... mod NUM_CH.
module arb_picker
  import arb_types::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int IDX_W  = idx_width(DEF_NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IDX_W-1:0]  start_i,
  output logic [IDX_W-1:0]  idx_o,
  output logic              valid_o
);

  logic [IDX_W:0] cand;

  // Scan from the farthest offset down so the nearest requester is the last to write idx_o.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      cand = {1'b0, start_i} + (IDX_W + 1)'(k);
      if (cand >= (IDX_W + 1)'(NUM_CH)) begin
        cand = cand - (IDX_W + 1)'(NUM_CH);
      end
      if (req_i[cand[IDX_W-1:0]]) begin
        idx_o   = cand[IDX_W-1:0];
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_n.sv
// Arbitrates NUM_CH cache-line requesters onto one downstream memory port, one transaction at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise lowest channel index wins.
module mem_arbiter_n
  import arb_types::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LINE_W = DEF_LINE_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req_read,
  input  logic [NUM_CH-1:0]        req_write,
  input  logic [NUM_CH*ADDR_W-1:0] req_address,
  input  logic [NUM_CH*LINE_W-1:0] req_wdata,
  output logic [LINE_W-1:0]        req_rdata,
  output logic [NUM_CH-1:0]        req_resp,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [ADDR_W-1:0]        mem_address,
  output logic [LINE_W-1:0]        mem_wdata,
  input  logic [LINE_W-1:0]        mem_rdata,
  input  logic                     mem_resp
);

  localparam int IDX_W = idx_width(NUM_CH);

  arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;

  logic [ADDR_W-1:0] ch_addr  [NUM_CH];
  logic [LINE_W-1:0] ch_wdata [NUM_CH];
  logic [IDX_W-1:0]  start_ptr;
  logic [IDX_W-1:0]  win_idx;
  logic              win_valid;
  logic              busy;
  logic              resp_fire;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
    assign ch_addr[gi]  = req_address[gi*ADDR_W +: ADDR_W];
    assign ch_wdata[gi] = req_wdata[gi*LINE_W +: LINE_W];
    assign req_resp[gi] = resp_fire && (grant_q == IDX_W'(gi));
  end

  assign busy      = (state_q == BUSY);
  assign resp_fire = busy && mem_resp;

`ifdef ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;

  assign start_ptr = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (resp_fire) begin
      ptr_d = (grant_q == IDX_W'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`else
  assign start_ptr = '0;
`endif

  arb_picker #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_picker (
    .req_i   (req_read | req_write),
    .start_i (start_ptr),
    .idx_o   (win_idx),
    .valid_o (win_valid)
  );

  // A channel raising read and write together is latched as a write.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d = BUSY;
          grant_d = win_idx;
          write_d = req_write[win_idx];
          addr_d  = ch_addr[win_idx];
          wdata_d = ch_wdata[win_idx];
        end
      end
      BUSY: begin
        if (mem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_read    = busy && !write_q;
  assign mem_write   = busy && write_q;
  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;
  assign req_rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Scoreboard bench for mem_arbiter_n (4 channels); expected grant order follows ARB_ROUND_ROBIN_EN.
module tb_mem_arbiter_n;

  localparam int NCH = 4;
  localparam int AW  = 32;
  localparam int LW  = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NCH-1:0]    req_read, req_write;
  logic [AW-1:0]     ch_addr  [NCH];
  logic [LW-1:0]     ch_wdata [NCH];
  logic [NCH*AW-1:0] req_address;
  logic [NCH*LW-1:0] req_wdata;
  logic [LW-1:0]     req_rdata;
  logic [NCH-1:0]    req_resp;
  logic              mem_read, mem_write;
  logic [AW-1:0]     mem_address;
  logic [LW-1:0]     mem_wdata;
  logic [LW-1:0]     mem_rdata;
  logic              mem_resp;
  logic              rsp_q, poke;
  int                rcnt;

  assign mem_resp = rsp_q | poke;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_pack
    assign req_address[gi*AW +: AW] = ch_addr[gi];
    assign req_wdata[gi*LW +: LW]   = ch_wdata[gi];
  end

  mem_arbiter_n #(.NUM_CH(NCH), .ADDR_W(AW), .LINE_W(LW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_read    (req_read),
    .req_write   (req_write),
    .req_address (req_address),
    .req_wdata   (req_wdata),
    .req_rdata   (req_rdata),
    .req_resp    (req_resp),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_resp    (mem_resp)
  );

  typedef struct {
    int          ch;
    bit          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] rdata;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic push(input int ch, input bit wr, input logic [AW-1:0] a,
                      input logic [LW-1:0] wd, input logic [LW-1:0] rd);
    exp_t e;
    e.ch = ch; e.wr = wr; e.addr = a; e.wdata = wd; e.rdata = rd;
    sb.push_back(e);
  endtask

  // Requests still pending after a response are dropped by the owning channel when drop_en is set.
  task automatic run(input int n, input int budget, input bit drop_en);
    int got;
    int cyc;
    logic [NCH-1:0] d;
    got = 0;
    cyc = 0;
    while (got < n && cyc < budget) begin
      @(negedge clk);
      d = req_resp;
      if (d != '0) got++;
      @(posedge clk); #1;
      if (drop_en) begin
        req_read  = req_read & ~d;
        req_write = req_write & ~d;
      end
      cyc++;
    end
    if (got < n) begin
      vectors++;
      miscompares++;
      $display("FAIL run_timeout: got %0d responses, required %0d", got, n);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Memory model: responds 5 cycles into each command with a line derived from the address.
  initial begin
    rsp_q = 1'b0;
    mem_rdata = '0;
    rcnt = 0;
    forever begin
      @(posedge clk); #1;
      if (mem_read || mem_write) begin
        rcnt++;
        if (rcnt == 5) begin
          rsp_q = 1'b1;
          mem_rdata = {mem_address, ~mem_address};
        end else begin
          rsp_q = 1'b0;
          mem_rdata = '0;
        end
      end else begin
        rcnt = 0;
        rsp_q = 1'b0;
        mem_rdata = '0;
      end
    end
  end

  // Monitor: checks the downstream command against the scoreboard head and pops on each response.
  initial begin
    bit   prev_resp;
    exp_t e;
    prev_resp = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("rd_wr_exclusive", 64'(mem_read & mem_write), 64'd0);
        if (prev_resp) chk("idle_gap", 64'(mem_read | mem_write), 64'd0);
        if (mem_read || mem_write) begin
          if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_cmd: addr %h with empty scoreboard", mem_address);
          end else begin
            e = sb[0];
            chk("cmd_write", 64'(mem_write), 64'(e.wr));
            chk("cmd_addr", 64'(mem_address), 64'(e.addr));
            if (e.wr) chk("cmd_wdata", 64'(mem_wdata), 64'(e.wdata));
          end
        end
        if (req_resp != '0) begin
          if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_resp: req_resp %b with empty scoreboard", req_resp);
          end else begin
            e = sb.pop_front();
            chk("resp_onehot", 64'(req_resp), 64'(4'b0001 << e.ch));
            if (!e.wr) chk("resp_rdata", 64'(req_rdata), 64'(e.rdata));
          end
        end
        prev_resp = (req_resp != '0);
      end else begin
        prev_resp = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    poke = 1'b0;
    req_read = '0;
    req_write = '0;
    for (int i = 0; i < NCH; i++) begin
      ch_addr[i] = '0;
      ch_wdata[i] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_mem_read", 64'(mem_read), 64'd0);
    chk("reset_mem_write", 64'(mem_write), 64'd0);
    chk("reset_req_resp", 64'(req_resp), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single read on ch1 with cycle-exact latency checks.
    ch_addr[1] = 32'h0000_0040;
    req_read[1] = 1'b1;
    push(1, 1'b0, 32'h40, '0, 64'h0000_0040_FFFF_FFBF);
    @(posedge clk); #1;
    req_read[1] = 1'b0;
    @(negedge clk);
    chk("v1_mem_read_c1", 64'(mem_read), 64'd1);
    chk("v1_mem_addr_c1", 64'(mem_address), 64'h40);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("v1_req_resp_c5", 64'(req_resp), 64'b0010);
    chk("v1_rdata_c5", 64'(req_rdata), 64'h0000_0040_FFFF_FFBF);
    @(posedge clk);
    @(negedge clk);
    chk("v1_idle_c6", 64'(mem_read), 64'd0);

    // ch0 write vs ch1 read from a fresh pointer.
    do_reset();
    ch_addr[0] = 32'h1000; ch_wdata[0] = 64'h1111_2222_3333_4444; req_write[0] = 1'b1;
    ch_addr[1] = 32'h1040; req_read[1] = 1'b1;
    push(0, 1'b1, 32'h1000, 64'h1111_2222_3333_4444, '0);
    push(1, 1'b0, 32'h1040, '0, 64'h0000_1040_FFFF_EFBF);
    run(2, 100, 1'b1);

    // Lone ch0 read moves the round-robin pointer to ch1.
    ch_addr[0] = 32'h80; req_read[0] = 1'b1;
    push(0, 1'b0, 32'h80, '0, 64'h0000_0080_FFFF_FF7F);
    run(1, 100, 1'b1);

    // Same contention again.
    ch_addr[0] = 32'h1000; req_write[0] = 1'b1;
    ch_addr[1] = 32'h1040; req_read[1] = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
    push(1, 1'b0, 32'h1040, '0, 64'h0000_1040_FFFF_EFBF);
    push(0, 1'b1, 32'h1000, 64'h1111_2222_3333_4444, '0);
`else
    push(0, 1'b1, 32'h1000, 64'h1111_2222_3333_4444, '0);
    push(1, 1'b0, 32'h1040, '0, 64'h0000_1040_FFFF_EFBF);
`endif
    run(2, 100, 1'b1);

    // All four channels request continuously.
    do_reset();
    for (int i = 0; i < NCH; i++) ch_addr[i] = 32'h400 + 32'(i) * 32'h10;
    req_read = '1;
`ifdef ARB_ROUND_ROBIN_EN
    push(0, 1'b0, 32'h400, '0, 64'h0000_0400_FFFF_FBFF);
    push(1, 1'b0, 32'h410, '0, 64'h0000_0410_FFFF_FBEF);
    push(2, 1'b0, 32'h420, '0, 64'h0000_0420_FFFF_FBDF);
    push(3, 1'b0, 32'h430, '0, 64'h0000_0430_FFFF_FBCF);
    push(0, 1'b0, 32'h400, '0, 64'h0000_0400_FFFF_FBFF);
`else
    for (int i = 0; i < 5; i++) push(0, 1'b0, 32'h400, '0, 64'h0000_0400_FFFF_FBFF);
`endif
    run(5, 200, 1'b0);
    req_read = '0;

    // ch2 changes its address while its read is in flight.
    ch_addr[2] = 32'h100; req_read[2] = 1'b1;
    push(2, 1'b0, 32'h100, '0, 64'h0000_0100_FFFF_FEFF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    ch_addr[2] = 32'h200;
    run(1, 100, 1'b1);

    // Reset lands in BUSY cycle 3 of a ch1 write.
    ch_addr[1] = 32'h500; ch_wdata[1] = 64'hABCD_0000_0000_0500; req_write[1] = 1'b1;
    push(1, 1'b1, 32'h500, 64'hABCD_0000_0000_0500, '0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    req_write = '0;
    @(negedge clk);
    chk("rst_c3_mem_write", 64'(mem_write), 64'd1);
    chk("rst_c3_req_resp", 64'(req_resp), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("rst_c4_mem_write", 64'(mem_write), 64'd0);
    chk("rst_c4_req_resp", 64'(req_resp), 64'd0);
    @(posedge clk); #1;
    ch_addr[0] = 32'h600; req_read[0] = 1'b1;
    ch_addr[3] = 32'h700; req_read[3] = 1'b1;
    push(0, 1'b0, 32'h600, '0, 64'h0000_0600_FFFF_F9FF);
    push(3, 1'b0, 32'h700, '0, 64'h0000_0700_FFFF_F8FF);
    run(2, 100, 1'b1);

    // Read and write together on ch3 is a write.
    ch_addr[3] = 32'h300; ch_wdata[3] = 64'hCAFE_0000_0000_0003;
    req_read[3] = 1'b1; req_write[3] = 1'b1;
    push(3, 1'b1, 32'h300, 64'hCAFE_0000_0000_0003, '0);
    run(1, 100, 1'b1);

    // A stray mem_resp while idle must be ignored.
    @(posedge clk); #1;
    poke = 1'b1;
    @(negedge clk);
    chk("idle_poke_req_resp", 64'(req_resp), 64'd0);
    @(posedge clk); #1;
    poke = 1'b0;
    @(negedge clk);
    chk("idle_poke_no_cmd", 64'(mem_read | mem_write), 64'd0);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
